// File: rtl/dequant_scale_loader.sv
// ---------------------------------------------------------------------------
// dequant_scale_loader
//
// Streams dequantisation scale words from a valid/ready source into the
// dequant scale RAM. A load is started by a one-cycle start pulse. It then
// accepts pBLOCK_RAM_NUM * pDEQUANT_SCALE_NUM beats in scale-major order:
// the block counter advances on every beat, and the scale counter advances
// each time the block counter wraps. Every accepted beat becomes one
// registered write, one cycle later, to pWEIGHT_BASE_ADDR + scale index.
//
// Handshake: s_ready is high exactly while the FSM is in LOAD. A beat
// transfers on a rising edge where s_valid && s_ready. The source may drop
// s_valid at any time to stall the load.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        one-cycle load request (only honoured in IDLE)
//   abort        synchronous cancel (only honoured in LOAD)
//   s_valid/s_ready/s_data   source word stream
//   wr_en/weight_addr/weight_data   registered RAM write port
//   busy         high in LOAD and DONE
//   done         one-cycle pulse, coincident with the final write
// ---------------------------------------------------------------------------
module dequant_scale_loader #(
   parameter int          pWEIGHT_DATA_WIDTH = 64,
   parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
   parameter int          pDEQUANT_SCALE_NUM = 32,
   parameter int          pBLOCK_RAM_NUM     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [pWEIGHT_DATA_WIDTH-1:0] s_data,
   output logic                          wr_en,
   output logic [31:0]                   weight_addr,
   output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
   output logic                          busy,
   output logic                          done
);

   localparam int BLK_W = (pBLOCK_RAM_NUM > 1) ? $clog2(pBLOCK_RAM_NUM) : 1;
   localparam int SCL_W = (pDEQUANT_SCALE_NUM > 1) ? $clog2(pDEQUANT_SCALE_NUM) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(pBLOCK_RAM_NUM - 1);
   localparam logic [SCL_W-1:0] SCL_LAST = SCL_W'(pDEQUANT_SCALE_NUM - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [BLK_W-1:0]                blk_cnt_q, blk_cnt_d;
   logic [SCL_W-1:0]                scl_cnt_q, scl_cnt_d;
   logic                            wr_en_q, wr_en_d;
   logic [31:0]                     addr_q, addr_d;
   logic [pWEIGHT_DATA_WIDTH-1:0]   data_q, data_d;
   logic                            accept;
   logic                            last_beat;

   assign accept    = s_valid && (state_q == ST_LOAD);
   assign last_beat = (blk_cnt_q == BLK_LAST) && (scl_cnt_q == SCL_LAST);

   always_comb begin
      state_d   = state_q;
      blk_cnt_d = blk_cnt_q;
      scl_cnt_d = scl_cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      // The write strobe follows the accept by exactly one cycle, even in
      // a cycle where abort also fires.
      wr_en_d   = accept;

      if (accept) begin
         addr_d = pWEIGHT_BASE_ADDR + 32'(scl_cnt_q);
         data_d = s_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_LOAD;
               blk_cnt_d = '0;
               scl_cnt_d = '0;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d   = ST_IDLE;
               blk_cnt_d = '0;
               scl_cnt_d = '0;
            end else if (accept) begin
               if (last_beat) begin
                  state_d   = ST_DONE;
                  blk_cnt_d = '0;
                  scl_cnt_d = '0;
               end else if (blk_cnt_q == BLK_LAST) begin
                  blk_cnt_d = '0;
                  scl_cnt_d = scl_cnt_q + SCL_W'(1);
               end else begin
                  blk_cnt_d = blk_cnt_q + BLK_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         blk_cnt_q <= '0;
         scl_cnt_q <= '0;
         wr_en_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         blk_cnt_q <= blk_cnt_d;
         scl_cnt_q <= scl_cnt_d;
         wr_en_q   <= wr_en_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   assign s_ready     = (state_q == ST_LOAD);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign wr_en       = wr_en_q;
   assign weight_addr = addr_q;
   assign weight_data = data_q;

endmodule

// File: tb/tb_dequant_scale_loader.sv
// ---------------------------------------------------------------------------
// tb_dequant_scale_loader
//
// Directed bench for dequant_scale_loader. u_dut runs a small 2x4 geometry
// for the directed scenarios. u_big keeps the default 32x32 geometry for the
// long load. Every write leaving u_dut is matched against an expected queue
// filled by the driver tasks.
// ---------------------------------------------------------------------------
module tb_dequant_scale_loader;

   localparam int          DW   = 64;
   localparam logic [31:0] BASE = 32'h4000_0000;

   // clock / reset
   logic clk;
   logic rst;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // small DUT (2 block RAMs x 4 scales)
   logic          start, abort, s_valid, s_ready, wr_en, busy, done;
   logic [DW-1:0] s_data, weight_data;
   logic [31:0]   weight_addr;

   dequant_scale_loader #(
      .pWEIGHT_DATA_WIDTH (DW),
      .pWEIGHT_BASE_ADDR  (BASE),
      .pDEQUANT_SCALE_NUM (4),
      .pBLOCK_RAM_NUM     (2)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .wr_en       (wr_en),
      .weight_addr (weight_addr),
      .weight_data (weight_data),
      .busy        (busy),
      .done        (done)
   );

   // default-geometry DUT (32 x 32)
   logic          big_start, big_abort, big_s_valid, big_s_ready;
   logic          big_wr_en, big_busy, big_done;
   logic [DW-1:0] big_s_data, big_weight_data;
   logic [31:0]   big_weight_addr;

   dequant_scale_loader u_big (
      .clk         (clk),
      .rst         (rst),
      .start       (big_start),
      .abort       (big_abort),
      .s_valid     (big_s_valid),
      .s_ready     (big_s_ready),
      .s_data      (big_s_data),
      .wr_en       (big_wr_en),
      .weight_addr (big_weight_addr),
      .weight_data (big_weight_data),
      .busy        (big_busy),
      .done        (big_done)
   );

   // scoreboard state
   int            checks   = 0;
   int            failures = 0;
   logic [95:0]   exp_q[$];      // {addr, data}
   logic [95:0]   mon_e;
   int            beat_idx = 0;
   int            wr_cnt   = 0;
   int            done_cnt = 0;
   int            big_cnt  = 0;
   int            big_done_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // write monitors
   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_wr", 1'b1, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check_val("wr_addr", weight_addr, mon_e[95:64]);
            check_val("wr_data", weight_data, mon_e[63:0]);
         end
      end
      if (done) begin
         done_cnt++;
         check_val("done_with_wr", wr_en, 1'b1);
      end
      if (big_wr_en) begin
         check_val("big_wr_data", big_weight_data, 64'(big_cnt + 1));
         check_val("big_wr_addr", big_weight_addr, BASE + 32'(big_cnt / 32));
         big_cnt++;
      end
      if (big_done) begin
         big_done_cnt++;
         check_val("big_done_with_wr", big_wr_en, 1'b1);
         check_val("big_done_cnt", big_cnt, 1024);
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic ab);
      start    = 1'b1;
      abort    = ab;
      beat_idx = 0;
      tick();
      start = 1'b0;
      abort = 1'b0;
   endtask

   // One accepted beat; the bench expects the loader to be ready here.
   task automatic send_beat(input logic [DW-1:0] d, input logic st, input logic ab);
      check_val("s_ready_beat", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = d;
      start   = st;
      abort   = ab;
      exp_q.push_back({BASE + 32'(beat_idx / 2), d});
      beat_idx++;
      tick();
      s_valid = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
   endtask

   // Full 8-beat load; poke pulses start during LOAD and in the DONE cycle.
   task automatic full_load(input logic [DW-1:0] base_d, input logic poke,
                            input logic ab_at_start);
      wr_cnt   = 0;
      done_cnt = 0;
      do_start(ab_at_start);
      for (int k = 0; k < 8; k++) send_beat(base_d + DW'(k), poke && (k == 3), 1'b0);
      check_val("done_cycle_done", done, 1'b1);
      check_val("done_cycle_busy", busy, 1'b1);
      check_val("done_cycle_ready", s_ready, 1'b0);
      check_val("done_cycle_addr", weight_addr, 32'h4000_0003);
      start = poke;
      abort = poke;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_val("after_done_busy", busy, 1'b0);
      check_val("after_done_done", done, 1'b0);
      check_val("after_done_wr", wr_en, 1'b0);
      tick();
      check_val("idle_busy", busy, 1'b0);
      check_val("load_wr_cnt", wr_cnt, 8);
      check_val("load_done_cnt", done_cnt, 1);
      check_val("load_q_empty", exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
      big_start = 1'b0; big_abort = 1'b0; big_s_valid = 1'b0; big_s_data = '0;

      // reset state
      #3;
      check_val("rst_s_ready", s_ready, 1'b0);
      check_val("rst_wr_en", wr_en, 1'b0);
      check_val("rst_addr", weight_addr, 32'h0);
      check_val("rst_data", weight_data, 64'h0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // full back-to-back load
      full_load(64'h10, 1'b0, 1'b0);

      // stalls: s_valid toggles 1/0 every cycle
      wr_cnt = 0;
      done_cnt = 0;
      do_start(1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) begin
            s_valid = 1'b1;
            s_data  = 64'h30 + 64'(i / 2);
            exp_q.push_back({BASE + 32'(i / 4), 64'h30 + 64'(i / 2)});
         end else begin
            s_valid = 1'b0;
         end
         tick();
         s_valid = 1'b0;
         @(negedge clk);
         check_val("stall_wr", wr_en, (i % 2 == 0));
         check_val("stall_done", done, (i == 14));
      end
      check_val("stall_idle_busy", busy, 1'b0);
      tick();
      check_val("stall_wr_cnt", wr_cnt, 8);
      check_val("stall_q_empty", exp_q.size(), 0);

      // abort arriving with the third beat; that beat still writes
      wr_cnt = 0;
      done_cnt = 0;
      do_start(1'b0);
      send_beat(64'h20, 1'b0, 1'b0);
      send_beat(64'h21, 1'b0, 1'b0);
      send_beat(64'h22, 1'b0, 1'b1);
      check_val("abort_ready", s_ready, 1'b0);
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_wr", wr_en, 1'b1);
      check_val("abort_addr", weight_addr, 32'h4000_0001);
      tick();
      tick();
      check_val("abort_wr_cnt", wr_cnt, 3);
      check_val("abort_no_done", done_cnt, 0);
      // restart from entry 0; abort alongside start in IDLE is ignored
      full_load(64'h40, 1'b0, 1'b1);

      // asynchronous reset after 5 beats
      wr_cnt = 0;
      done_cnt = 0;
      do_start(1'b0);
      for (int k = 0; k < 5; k++) send_beat(64'h50 + 64'(k), 1'b0, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("arst_s_ready", s_ready, 1'b0);
      check_val("arst_wr_en", wr_en, 1'b0);
      check_val("arst_addr", weight_addr, 32'h0);
      check_val("arst_data", weight_data, 64'h0);
      check_val("arst_busy", busy, 1'b0);
      check_val("arst_done", done, 1'b0);
      check_val("arst_wr_cnt", wr_cnt, 5);
      @(posedge clk);
      #2 rst = 1'b0;
      s_valid = 1'b1;
      s_data  = 64'hdead;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_val("arst_no_ready", s_ready, 1'b0);
      end
      s_valid = 1'b0;
      tick();
      check_val("arst_no_more_wr", wr_cnt, 5);
      check_val("arst_no_done", done_cnt, 0);

      // start pulsed during LOAD and in the DONE cycle is ignored
      full_load(64'h60, 1'b1, 1'b0);

      // default geometry: 1024 beats
      big_start = 1'b1;
      tick();
      big_start = 1'b0;
      check_val("big_ready", big_s_ready, 1'b1);
      for (int k = 0; k < 1024; k++) begin
         big_s_valid = 1'b1;
         big_s_data  = 64'(k + 1);
         tick();
      end
      big_s_valid = 1'b0;
      @(negedge clk);
      #1;
      check_val("big_done", big_done, 1'b1);
      check_val("big_final_addr", big_weight_addr, 32'h4000_001F);
      check_val("big_wr_total", big_cnt, 1024);
      tick();
      check_val("big_idle_busy", big_busy, 1'b0);
      check_val("big_done_total", big_done_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
